// File: rtl/md_pkg.sv
// Shared opcodes, FSM encoding and default latencies for the multiply/divide unit.
// MADD/MADDU/MSUB/MSUBU are only recognised when MD_MADD_EN is defined.
package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MADD  = 4'd7;
    localparam logic [3:0] MD_MADDU = 4'd8;
    localparam logic [3:0] MD_MSUB  = 4'd9;
    localparam logic [3:0] MD_MSUBU = 4'd10;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Ops that occupy the unit for several cycles and stall the pipe.
    function automatic logic is_long_op(input logic [3:0] op);
        logic r;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        logic r;
        case (op)
            MD_DIV, MD_DIVU: r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit {HI,LO} result generator for mult/div (and madd/msub
// when MD_MADD_EN is defined). Ops that leave HI/LO alone return {hi, lo}.
module md_calc
    import md_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res
);

    logic signed [31:0] as_s;
    logic signed [31:0] bs_s;
    logic signed [63:0] smul_s;
    logic        [63:0] umul_s;
    logic               b_zero_s;
    logic               sdiv_ovf_s;

    assign as_s       = $signed(a);
    assign bs_s       = $signed(b);
    assign smul_s     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign umul_s     = {32'd0, a} * {32'd0, b};
    assign b_zero_s   = (b == 32'd0);
    // Most-negative / -1 overflows the quotient; the architectural answer is fixed.
    assign sdiv_ovf_s = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Select the 64-bit result for the requested op.
    always_comb begin
        res = {hi, lo};
        case (op)
            MD_MULT:  res = smul_s;
            MD_MULTU: res = umul_s;
            MD_DIV: begin
                if (b_zero_s) begin
                    res = {hi, lo};
                end else if (sdiv_ovf_s) begin
                    res = {32'd0, 32'h8000_0000};
                end else begin
                    res = {32'(as_s % bs_s), 32'(as_s / bs_s)};
                end
            end
            MD_DIVU: begin
                if (b_zero_s) begin
                    res = {hi, lo};
                end else begin
                    res = {a % b, a / b};
                end
            end
`ifdef MD_MADD_EN
            MD_MADD:  res = {hi, lo} + smul_s;
            MD_MADDU: res = {hi, lo} + umul_s;
            MD_MSUB:  res = {hi, lo} - smul_s;
            MD_MSUBU: res = {hi, lo} - umul_s;
`endif
            default:  res = {hi, lo};
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide controller: latches the result at issue, holds
// Busy for a fixed latency, then commits HI/LO. Optional MD_MADD_EN adds madd/msub.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDOp,
    input  logic        Start,
    input  logic        Flush,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e          state_r;
    md_state_e          state_nx_s;
    logic               busy_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [31:0]        ph_r;
    logic [31:0]        pl_r;
    logic [31:0]        hi_r;
    logic [31:0]        lo_r;
    logic [63:0]        calc_s;
    logic               accept_s;
    logic               accept_long_s;
    logic               last_s;
    logic               stall_s;

    md_calc u_calc (
        .a   (A),
        .b   (B),
        .op  (MDOp),
        .hi  (hi_r),
        .lo  (lo_r),
        .res (calc_s)
    );

    // Flushed commands and anything arriving while busy are ignored.
    assign accept_s      = Start & ~Flush & (state_r == ST_IDLE);
    assign accept_long_s = accept_s & is_long_op(MDOp);
    assign last_s        = (state_r == ST_RUN) && (cnt_r == CNT_W'(1));

    // State register; Busy is registered alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == ST_RUN);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_long_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Stall must rise in the issue cycle itself, so it is combinational.
    always_comb begin
        stall_s = busy_r | (Start & is_long_op(MDOp));
    end

    // Counter, pending result and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
            ph_r  <= 32'd0;
            pl_r  <= 32'd0;
            hi_r  <= 32'd0;
            lo_r  <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_long_s) begin
                        {ph_r, pl_r} <= calc_s;
                        cnt_r        <= is_div_op(MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    end else if (accept_s && (MDOp == MD_MTHI)) begin
                        hi_r <= A;
                    end else if (accept_s && (MDOp == MD_MTLO)) begin
                        lo_r <= A;
                    end
                end
                ST_RUN: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (last_s) begin
                        hi_r <= ph_r;
                        lo_r <= pl_r;
                    end
                end
                default: cnt_r <= '0;
            endcase
        end
    end

    assign Busy  = busy_r;
    assign Stall = stall_s;
    assign HI    = hi_r;
    assign LO    = lo_r;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed self-checking bench for md_ctrl: latency, arithmetic corner cases,
// flush and reset behaviour, with hand-computed expected HI/LO values.
module tb_md_ctrl;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [3:0]  MDOp = 4'd0;
    logic        Start = 1'b0;
    logic        Flush = 1'b0;
    logic        Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    md_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MDOp  (MDOp),
        .Start (Start),
        .Flush (Flush),
        .Busy  (Busy),
        .Stall (Stall),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue a long op at a negedge, then count Busy cycles; optional Flush/reset in RUN cycle k.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input int flush_at,
                          input int reset_at, input logic [31:0] ehi, input logic [31:0] elo);
        int k;
        chk({tag, "_no_start_while_busy"}, {31'd0, Busy}, 32'd0);
        MDOp = op; A = a; B = b; Start = 1'b1;
        #1;
        chk({tag, "_stall_issue"}, {31'd0, Stall}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0; MDOp = MD_NONE;
        k = 0;
        while (Busy && k < 40) begin
            k++;
            Flush = (k == flush_at);
            reset = (k == reset_at);
            @(negedge clk);
        end
        Flush = 1'b0;
        reset = 1'b0;
        chk({tag, "_busy_cycles"}, 32'(k), 32'(n));
        chk({tag, "_hi"}, HI, ehi);
        chk({tag, "_lo"}, LO, elo);
    endtask

    // Single-cycle MTHI/MTLO (or any short op) at a negedge.
    task automatic short_op(input logic [3:0] op, input logic [31:0] a, input logic fl);
        MDOp = op; A = a; Start = 1'b1; Flush = fl;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0; Flush = 1'b0; MDOp = MD_NONE;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_stall", {31'd0, Stall}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);

        run_op("mult_neg", MD_MULT,  32'hFFFF_FFFE, 32'd3, 5, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("divu",     MD_DIVU,  32'd7,         32'd2, 10, 0, 0, 32'd1,        32'd3);
        run_op("div_neg",  MD_DIV,   32'hFFFF_FFF9, 32'd2, 10, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf",  MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 0, 0, 32'd0, 32'h8000_0000);
        run_op("div_zero", MD_DIV,   32'd5,         32'd0, 10, 0, 0, 32'd0,        32'h8000_0000);

        short_op(MD_MTHI, 32'h0000_1234, 1'b1);
        chk("mthi_flush_hi", HI, 32'd0);
        chk("mthi_flush_busy", {31'd0, Busy}, 32'd0);
        short_op(MD_MTHI, 32'h0000_1234, 1'b0);
        chk("mthi_hi", HI, 32'h0000_1234);
        chk("mthi_busy", {31'd0, Busy}, 32'd0);
        chk("mthi_lo_kept", LO, 32'h8000_0000);

        run_op("multu_flush", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 2, 0, 32'd1, 32'hFFFF_FFFE);

        // Reset lands in the 3rd RUN cycle: abort, clear, never commit.
        run_op("reset_mid", MD_MULT, 32'd3, 32'd4, 3, 0, 3, 32'd0, 32'd0);
        repeat (8) @(negedge clk);
        chk("reset_mid_late_hi", HI, 32'd0);
        chk("reset_mid_late_lo", LO, 32'd0);
        chk("reset_mid_late_busy", {31'd0, Busy}, 32'd0);

        // Start together with Flush: command dropped entirely.
        short_op(MD_MTLO, 32'h0000_5678, 1'b0);
        chk("mtlo_lo", LO, 32'h0000_5678);
        short_op(MD_DIVU, 32'd100, 1'b1);
        chk("flushed_div_busy", {31'd0, Busy}, 32'd0);
        repeat (12) @(negedge clk);
        chk("flushed_div_lo", LO, 32'h0000_5678);
        chk("flushed_div_hi", HI, 32'd0);

        MDOp = MD_NONE; Start = 1'b1;
        #1;
        chk("none_stall", {31'd0, Stall}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        chk("none_busy", {31'd0, Busy}, 32'd0);
        chk("none_lo", LO, 32'h0000_5678);

`ifdef MD_MADD_EN
        short_op(MD_MTLO, 32'd10, 1'b0);
        run_op("madd", MD_MADD, 32'd3, 32'd4, 5, 0, 0, 32'd0, 32'd22);
        run_op("msubu", MD_MSUBU, 32'd2, 32'd12, 5, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
`else
        B = 32'd4;
        MDOp = MD_MADD; A = 32'd3; Start = 1'b1;
        #1;
        chk("madd_off_stall", {31'd0, Stall}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0; MDOp = MD_NONE;
        chk("madd_off_busy", {31'd0, Busy}, 32'd0);
        repeat (6) @(negedge clk);
        chk("madd_off_lo", LO, 32'h0000_5678);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multi-cycle multiply/divide controller with HI/LO registers.
- Sits in the EX stage beside the single-cycle ALU.
- Accepts mult/div/mt* commands, models fixed multi-cycle latency with a counter FSM, and raises Busy/Stall so the hazard unit holds mfhi/mflo and further MD instructions.
- Honours exception flush from CP0 so a cancelled instruction never commits HI/LO.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10: busy cycles for div/divu (≥1).
- CNT_W, 4: counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- A  in  32  operand rs (forwarded).
- B  in  32  operand rt (forwarded).
- MDOp  in  4  operation code (see package).
- Start  in  1  EX-stage instruction is a valid MD op this cycle.
- Flush  in  1  exception/interrupt taken this cycle; cancels the EX-stage op.
- Busy  out  1  computation in progress.
- Stall  out  1  Busy | (Start & MDOp is mult/div class); to hazard unit.
- HI  out  32  architectural HI.
- LO  out  32  architectural LO.

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-high. On reset: state IDLE, counter 0, Busy 0, HI 0, LO 0, pending result 0. Reset mid-RUN aborts with no HI/LO commit.
- States IDLE and RUN.
- IDLE, Start & !Flush & MDOp∈{MULT, MULTU, DIV, DIVU}:
  - Latch the 64-bit result in pending {PH, PL}.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Enter RUN; Busy=1 from the next cycle.
- RUN:
  - Counter decrements each cycle.
  - When counter==1: HI<=PH, LO<=PL, go to IDLE.
  - Busy is high for exactly N cycles. New HI/LO is visible the first cycle Busy=0.
- MTHI/MTLO with Start & !Flush in IDLE: HI or LO <= A on that edge (1-cycle latency), no Busy.
- Start & Flush: command ignored entirely; no state, HI or LO change.
- Flush during RUN has no effect. An already-issued op completes and commits.
- Start while Busy: ignored. The hazard unit guarantees this never happens; the bench asserts it.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI = upper 32 bits, LO = lower 32 bits.
  - multu: same, unsigned.
  - div: signed. LO = quotient truncated toward zero; HI = remainder, sign follows the dividend.
  - divu: unsigned.
  - Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divide by zero: op still runs the full DIV_CYCLES; HI and LO are left unchanged.
- MDOp NONE or an undefined code with Start: no-op.
- Stall is combinational and asserts in the Start cycle, so the next instruction holds without a bubble gap.

Optional Feature:
- MD_MADD_EN defined:
  - Adds MADD (7) and MADDU (8): {HI, LO} <= {HI, LO} + A*B (signed or unsigned), latency MULT_CYCLES.
  - Accumulation uses the HI/LO values present at issue.
  - Adds MSUB (9) and MSUBU (10): {HI, LO} <= {HI, LO} - A*B (signed or unsigned), latency MULT_CYCLES.
- MD_MADD_EN undefined: codes 7-10 are no-ops; the 64-bit adder is absent.

Decomposition:
- Package md_pkg:
  - MDOp localparams: NONE 0, MULT 1, MULTU 2, DIV 3, DIVU 4, MTHI 5, MTLO 6, MADD 7, MADDU 8, MSUB 9, MSUBU 10.
  - State encoding IDLE/RUN.
  - Default cycle constants.
- One sub-module, md_calc: purely combinational 64-bit result generator (mult/div/madd). The FSM, counter and HI/LO registers stay in md_ctrl.

Test Plan:
- Reset then MULT A=0xFFFFFFFE(-2), B=3 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; Stall high in the Start cycle.
- DIVU A=7, B=2 -> Busy 10 cycles; then LO=3, HI=1.
- DIV A=0xFFFFFFF9(-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV by zero -> HI/LO unchanged after 10 cycles.
- MTHI A=0x1234 with Flush=1 -> HI unchanged.
- Same MTHI with Flush=0 -> HI=0x1234 next cycle, Busy stays 0.
- Flush in the 2nd RUN cycle of MULTU 0xFFFFFFFF x 2 -> still commits HI=1, LO=0xFFFFFFFE.
- reset asserted in the 3rd RUN cycle -> Busy=0, HI=LO=0 next cycle, no later commit.
- (MD_MADD_EN) HI=0, LO=10; MADD A=3, B=4 -> after 5 cycles LO=22, HI=0.
